// File: rtl/priority_decoder_8to256.sv
// Registered index-to-one-hot decoder with an optional accumulate mask and valid/ready handshakes.
// Optional thermometer output enabled by defining DEC_THERMO_EN.
module priority_decoder_8to256 #(
   parameter int unsigned  IDX_W = 8,
   localparam int unsigned OUT_W = 2 ** IDX_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IDX_W-1:0] in_index,
   input  logic             in_accum,
   input  logic             clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_vector
`ifdef DEC_THERMO_EN
   ,
   output logic [OUT_W-1:0] out_thermo
`endif
);

   typedef enum logic {StEmpty, StFull} state_e;

   state_e             r_state;
   state_e             w_state_next;
   logic [OUT_W-1:0]   r_mask;
   logic [OUT_W-1:0]   r_vector;
   logic [OUT_W-1:0]   w_onehot;
   logic [OUT_W-1:0]   w_mask_base;
   logic [OUT_W-1:0]   w_mask_next;
   logic               w_accept;

   assign in_ready  = (r_state == StEmpty) | out_ready;
   assign w_accept  = in_valid & in_ready;
   assign out_valid = (r_state == StFull);
   assign out_vector = r_vector;

   assign w_onehot = {{(OUT_W-1){1'b0}}, 1'b1} << in_index;

   // A clear arriving with an accumulate accept wipes the old mask before the OR.
   assign w_mask_base = clear ? '0 : r_mask;
   assign w_mask_next = in_accum ? (w_mask_base | w_onehot) : w_onehot;

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StEmpty: if (w_accept) w_state_next = StFull;
         StFull:  if (out_ready && !w_accept) w_state_next = StEmpty;
         default: w_state_next = StEmpty;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StEmpty;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mask   <= '0;
         r_vector <= '0;
      end else if (w_accept) begin
         r_mask   <= w_mask_next;
         r_vector <= w_mask_next;
      end else if (clear) begin
         r_mask   <= '0;
      end
   end

`ifdef DEC_THERMO_EN
   logic [OUT_W-1:0] r_thermo;
   logic [OUT_W-1:0] w_thermo;

   // (onehot << 1) - 1; the top index wraps to 0 - 1, giving all ones.
   assign w_thermo   = {w_onehot[OUT_W-2:0], 1'b0} - {{(OUT_W-1){1'b0}}, 1'b1};
   assign out_thermo = r_thermo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_thermo <= '0;
      end else if (w_accept) begin
         r_thermo <= w_thermo;
      end
   end
`endif

endmodule
